snn_delay_layer_seq: RTL and testbench
======================================

Name: snn_delay_layer_seq

Overview:
Parametrised, time-multiplexed layer of leaky integrate-and-fire (LIF) neurons with per-synapse programmable axonal delays.
- Replaces the fixed-size, separately-clocked delay datapath with a single-clock sequential engine.
- One timestep is processed per accepted `step` pulse; a single accumulator sweeps all N×M synapses.
- Layers are cascaded by feeding one layer's `output_spikes` to the next layer's `input_spikes`, with `done` of one layer driving `step` of the next.

Parameters:
- M, 24: input channels (presynaptic).
- N, 8: neurons in this layer.
- NBITS, 2: weight width, signed two's complement.
- DW, 3: delay value width; the maximum delay is 2^DW−1 timesteps.
- PW, 6: membrane potential / threshold / decay width, unsigned.
- RW, 4: refractory counter width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: allows a step to be accepted.
- step, in, 1: timestep request pulse.
- input_spikes, in, M: spikes for this timestep; bit i is channel i.
- weights, in, N*M*NBITS: synapse (j,i) occupies slice [(j*M+i)*NBITS +: NBITS].
- delays, in, N*M*(DW+1): synapse (j,i) occupies slice [(j*M+i)*(DW+1) +: DW+1]; low DW bits are the delay value, MSB is the delay enable.
- threshold, in, PW: firing threshold.
- decay, in, PW: leak subtracted per timestep.
- refractory_period, in, RW: timesteps held silent after a spike.
- busy, out, 1: sweep in progress.
- done, out, 1: one-cycle pulse at the end of a timestep.
- overrun, out, 1: sticky; set when a step arrives while busy.
- output_spikes, out, N: spikes of the last completed timestep.
- membrane_potential_out, out, N*PW: neuron j occupies slice [j*PW +: PW].

Behaviour:
- Reset, synchronous: all outputs are 0; potentials, refractory counters, spike history and FSM are cleared; FSM goes to IDLE. Reset asserted mid-sweep aborts the sweep and no done is issued.
- Spike history: per input channel, a shift register of depth 2^DW. h[i][0] is the current timestep, h[i][d] is d steps ago. It shifts only in SHIFT.
- Effective spike for synapse (j,i): h[i][dval] if the delay enable is 1, else h[i][0]. Delay enable=1 with dval=0 is equivalent to no delay.
- FSM states: IDLE, SHIFT, ACCUM, UPDATE, DONE.
  - IDLE: step & enable at a clock edge moves to SHIFT; otherwise stay. busy=0.
  - SHIFT: 1 cycle. input_spikes are sampled into h[*][0]; older entries shift; j=0, i=0, acc=0.
  - ACCUM: M cycles per neuron. Each cycle adds the weight (sign-extended) if the effective spike is 1; i increments. After i=M−1, go to UPDATE.
  - UPDATE: 1 cycle for neuron j (rule below). If j<N−1 then j++, i=0, acc=0, go to ACCUM; else go to DONE.
  - DONE: 1 cycle. done=1 and output_spikes is loaded from the staging register. Return to IDLE.
- Latency: done is high exactly 2+N*(M+1) clocks after the accepting edge (202 at defaults). busy=1 in every state except IDLE.
- Accumulator: signed, width PW+NBITS+clog2(M)+1; it never overflows.
- Neuron update for neuron j:
  - If r_j>0: r_j−=1, V_j=0, spike_j=0.
  - Otherwise: V' = max(V_j−decay, 0) + acc, clamped to [0, 2^PW−1].
  - If V'>=threshold: spike_j=1, V_j=0, r_j=refractory_period.
  - Else: V_j=V', spike_j=0.
- membrane_potential_out reflects V_j directly and updates in UPDATE of neuron j. output_spikes changes only in DONE.
- threshold=0: every non-refractory neuron spikes on every step.
- step while busy: ignored, overrun<=1 (sticky until reset). step with enable=0 in IDLE: ignored, and overrun is not set.
- enable falling mid-sweep has no effect; the sweep completes.
- weights, delays, threshold, decay and refractory_period must be static while busy; behaviour is undefined if they change.

Test Plan:
1. Reset with defaults, then 10 idle clocks → all outputs 0, busy=0; step with enable=0 → no busy, no done, overrun=0.
2. w(0,0)=+1, all other weights 0, no delays, threshold=1, decay=0, refractory=0; input_spikes=1, step → done 202 clocks after accept, output_spikes=8'h01, V0=0.
3. As test 2 but delay(0,0)={en=1,val=3}; spike only at step 0, then steps with input 0 → output_spikes[0]=1 only after step 3 (steps 0,1,2 give 0).
4. All w(0,i)=+1, threshold=63, decay=0, all inputs 1 each step → V0=24, 48, then 63 (clamped from 72) spikes on step 2 with V0=0.
5. refractory_period=2, threshold=1, w(0,0)=+1, input 1 every step → neuron 0 spikes on steps 0,3,6; V0=0 during the refractory steps.
6. w(0,0)=−2, V0=1, decay=0, input 1 → V0=0 (clamped), no spike. Step pulsed at clock 50 of a sweep → ignored, overrun=1. Reset at clock 100 → busy=0 and no done follows.

Source files
------------

// File: rtl/snn_delay_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : snn_delay_layer_seq
//  Purpose  : Time-multiplexed layer of N leaky integrate-and-fire neurons with
//             M presynaptic channels and per-synapse programmable axonal
//             delays. One timestep is processed per accepted step pulse by a
//             single accumulator that sweeps every synapse in turn.
//  Ports    : clk, reset (sync, active high)
//             enable, step          - step request, accepted in IDLE only
//             input_spikes[M]       - spikes for the new timestep
//             weights[N*M*NBITS]    - synapse (j,i) at (j*M+i)*NBITS
//             delays[N*M*(DW+1)]    - synapse (j,i) at (j*M+i)*(DW+1),
//                                     MSB = delay enable, low DW bits = delay
//             threshold, decay      - firing threshold, leak per timestep
//             refractory_period     - silent timesteps after a spike
//             busy                  - sweep in progress
//             done                  - one-cycle pulse when a timestep completes
//             overrun               - sticky, step seen while busy
//             output_spikes[N]      - spikes of the last completed timestep
//             membrane_potential_out[N*PW] - neuron j at j*PW
//  Revision : 1.0 - initial release
// ============================================================================
module snn_delay_layer_seq #(
  parameter int M     = 24,
  parameter int N     = 8,
  parameter int NBITS = 2,
  parameter int DW    = 3,
  parameter int PW    = 6,
  parameter int RW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  step,
  input  logic [M-1:0]          input_spikes,
  input  logic [N*M*NBITS-1:0]  weights,
  input  logic [N*M*(DW+1)-1:0] delays,
  input  logic [PW-1:0]         threshold,
  input  logic [PW-1:0]         decay,
  input  logic [RW-1:0]         refractory_period,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [N-1:0]          output_spikes,
  output logic [N*PW-1:0]       membrane_potential_out
);

  localparam int DEPTH = 2**DW;
  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int JW    = (N > 1) ? $clog2(N) : 1;
  localparam int SW    = $clog2(N*M) + 1;
  localparam int AW    = PW + NBITS + $clog2(M) + 1;
  localparam logic [PW-1:0] VMAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [M-1:0]          hist_q [DEPTH];
  logic [IW-1:0]         i_q;
  logic [JW-1:0]         j_q;
  logic signed [AW-1:0]  acc_q;
  logic [PW-1:0]         pot_q [N];
  logic [RW-1:0]         ref_q [N];
  logic [N-1:0]          stage_q;

  // --------------------------------------------------------------------------
  // FSM: state register and next-state / status decode
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (step && enable) state_d = ST_SHIFT;
      end
      ST_SHIFT:  state_d = ST_ACCUM;
      ST_ACCUM:  if (i_q == IW'(M-1)) state_d = ST_UPDATE;
      ST_UPDATE: state_d = (j_q == JW'(N-1)) ? ST_DONE : ST_ACCUM;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Synapse selection for the current (j,i)
  // --------------------------------------------------------------------------
  logic [SW-1:0]        syn;
  logic [31:0]          wbase, dbase;
  logic [NBITS-1:0]     wsel;
  logic [DW:0]          dsel;
  logic [DW-1:0]        tap;
  logic [M-1:0]         hrow;
  logic                 eff;
  logic signed [AW-1:0] wext;

  assign syn   = SW'(j_q) * SW'(M) + SW'(i_q);
  assign wbase = 32'(syn) * 32'(NBITS);
  assign dbase = 32'(syn) * 32'(DW+1);
  assign wsel  = weights[wbase +: NBITS];
  assign dsel  = delays[dbase +: DW+1];
  // A disabled delay reads the newest history slot, same as delay value 0.
  assign tap   = dsel[DW] ? dsel[DW-1:0] : '0;
  assign hrow  = hist_q[tap];
  assign eff   = hrow[i_q];
  assign wext  = {{(AW-NBITS){wsel[NBITS-1]}}, wsel};

  // --------------------------------------------------------------------------
  // Neuron update arithmetic for neuron j
  // --------------------------------------------------------------------------
  logic [PW-1:0]        vcur, vleak, vnext;
  logic signed [AW-1:0] vsum;
  logic                 fire;

  always_comb begin
    vcur  = pot_q[j_q];
    vleak = (vcur > decay) ? (vcur - decay) : '0;
    vsum  = $signed({{(AW-PW){1'b0}}, vleak}) + acc_q;
    // Clamp the signed sum into the unsigned potential range.
    if (vsum[AW-1])           vnext = '0;
    else if (|vsum[AW-2:PW])  vnext = VMAX;
    else                      vnext = vsum[PW-1:0];
    fire = (vnext >= threshold);
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q           <= '0;
      j_q           <= '0;
      acc_q         <= '0;
      stage_q       <= '0;
      output_spikes <= '0;
      done          <= 1'b0;
      overrun       <= 1'b0;
      for (int d = 0; d < DEPTH; d++) hist_q[d] <= '0;
      for (int n = 0; n < N; n++) begin
        pot_q[n] <= '0;
        ref_q[n] <= '0;
      end
    end else begin
      // done is registered so it appears together with the new output_spikes.
      done <= (state_q == ST_DONE);
      if (step && (state_q != ST_IDLE)) overrun <= 1'b1;

      case (state_q)
        ST_SHIFT: begin
          hist_q[0] <= input_spikes;
          for (int d = 1; d < DEPTH; d++) hist_q[d] <= hist_q[d-1];
          i_q   <= '0;
          j_q   <= '0;
          acc_q <= '0;
        end
        ST_ACCUM: begin
          if (eff) acc_q <= acc_q + wext;
          i_q <= i_q + 1'b1;
        end
        ST_UPDATE: begin
          if (ref_q[j_q] != '0) begin
            ref_q[j_q]   <= ref_q[j_q] - 1'b1;
            pot_q[j_q]   <= '0;
            stage_q[j_q] <= 1'b0;
          end else if (fire) begin
            ref_q[j_q]   <= refractory_period;
            pot_q[j_q]   <= '0;
            stage_q[j_q] <= 1'b1;
          end else begin
            pot_q[j_q]   <= vnext;
            stage_q[j_q] <= 1'b0;
          end
          if (j_q != JW'(N-1)) begin
            j_q   <= j_q + 1'b1;
            i_q   <= '0;
            acc_q <= '0;
          end
        end
        ST_DONE: output_spikes <= stage_q;
        default: ;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < N; g++) begin : g_pot
      assign membrane_potential_out[g*PW +: PW] = pot_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_snn_delay_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snn_delay_layer_seq
//  Purpose  : Self-checking bench for snn_delay_layer_seq. Directed scenarios
//             followed by randomized timesteps compared against a timestep-
//             level reference model (spike history queue + per-neuron ints).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snn_delay_layer_seq;

  localparam int M     = 24;
  localparam int N     = 8;
  localparam int NBITS = 2;
  localparam int DW    = 3;
  localparam int PW    = 6;
  localparam int RW    = 4;
  localparam int LAT   = 2 + N*(M+1);
  localparam int VMAXI = (1 << PW) - 1;

  logic                  clk = 1'b0;
  logic                  reset, enable, step;
  logic [M-1:0]          input_spikes;
  logic [N*M*NBITS-1:0]  weights;
  logic [N*M*(DW+1)-1:0] delays;
  logic [PW-1:0]         threshold, decay;
  logic [RW-1:0]         refractory_period;
  logic                  busy, done, overrun;
  logic [N-1:0]          output_spikes;
  logic [N*PW-1:0]       membrane_potential_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snn_delay_layer_seq #(.M(M), .N(N), .NBITS(NBITS), .DW(DW), .PW(PW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .input_spikes(input_spikes), .weights(weights), .delays(delays),
    .threshold(threshold), .decay(decay), .refractory_period(refractory_period),
    .busy(busy), .done(done), .overrun(overrun),
    .output_spikes(output_spikes), .membrane_potential_out(membrane_potential_out)
  );

  // ---------------- reference model ----------------
  logic [M-1:0] mhist[$];   // mhist[0] = newest timestep
  int           mv[N];
  int           mr[N];
  logic [N-1:0] mspk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mhist.delete();
    for (int j = 0; j < N; j++) begin mv[j] = 0; mr[j] = 0; end
    mspk = '0;
  endtask

  task automatic model_step(input logic [M-1:0] in);
    int acc, w, d, vp;
    logic [DW:0] dl;
    mhist.push_front(in);
    if (mhist.size() > (1 << DW)) void'(mhist.pop_back());
    for (int j = 0; j < N; j++) begin
      acc = 0;
      for (int i = 0; i < M; i++) begin
        w  = $signed(weights[(j*M+i)*NBITS +: NBITS]);
        dl = delays[(j*M+i)*(DW+1) +: DW+1];
        d  = dl[DW] ? int'(dl[DW-1:0]) : 0;
        if (d < mhist.size() && mhist[d][i]) acc += w;
      end
      if (mr[j] > 0) begin
        mr[j]--; mv[j] = 0; mspk[j] = 1'b0;
      end else begin
        vp = ((mv[j] > int'(decay)) ? mv[j] - int'(decay) : 0) + acc;
        if (vp < 0) vp = 0;
        if (vp > VMAXI) vp = VMAXI;
        if (vp >= int'(threshold)) begin
          mspk[j] = 1'b1; mv[j] = 0; mr[j] = int'(refractory_period);
        end else begin
          mspk[j] = 1'b0; mv[j] = vp;
        end
      end
    end
  endtask

  function automatic logic [N*PW-1:0] model_mem();
    logic [N*PW-1:0] r;
    for (int j = 0; j < N; j++) r[j*PW +: PW] = mv[j][PW-1:0];
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; step = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_cfg(input int thr, input int dec, input int refr);
    weights = '0; delays = '0;
    threshold = PW'(thr); decay = PW'(dec); refractory_period = RW'(refr);
  endtask

  // One full timestep: accept, wait (bounded) for done, compare with model.
  task automatic run_step(input logic [M-1:0] in);
    int  k;
    bit  seen;
    @(negedge clk);
    input_spikes = in; step = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    enable = 1'($urandom_range(0, 1));  // must not affect the running sweep
    chk("busy_after_accept", busy, 1'b1);
    k = 0; seen = 0;
    while (!seen && k < 2*LAT) begin
      @(posedge clk); #1;
      k++;
      if (done) seen = 1;
    end
    chk("done_latency", k, LAT);
    model_step(in);
    chk("output_spikes", output_spikes, mspk);
    chk("membrane", membrane_potential_out, model_mem());
    chk("busy_at_done", busy, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
  endtask

  int          v0_exp[3];
  logic [6:0]  t5_exp;
  logic [3:0]  t3_exp;
  bit          seen_done;

  initial begin
    reset = 1'b1; enable = 1'b0; step = 1'b0; input_spikes = '0;
    clear_cfg(0, 0, 0);

    // ---- 1: reset, idle, step with enable low ----
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_spikes", output_spikes, '0);
    chk("rst_mem", membrane_potential_out, '0);
    @(negedge clk); step = 1'b1; enable = 1'b0; input_spikes = '1;
    @(negedge clk); step = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (busy || done) seen_done = 1;
    end
    chk("noenable_activity", seen_done, 1'b0);
    chk("noenable_overrun", overrun, 1'b0);

    // ---- 2: single synapse fires ----
    do_reset();
    clear_cfg(1, 0, 0);
    weights[0 +: NBITS] = 2'b01;
    run_step(24'h000001);
    chk("t2_spikes", output_spikes, 8'h01);
    chk("t2_v0", membrane_potential_out[0 +: PW], 0);

    // ---- 3: delayed synapse ----
    do_reset();
    clear_cfg(1, 0, 0);
    weights[0 +: NBITS] = 2'b01;
    delays[0 +: DW+1]   = {1'b1, 3'd3};
    t3_exp = 4'b1000;
    for (int s = 0; s < 4; s++) begin
      run_step((s == 0) ? 24'h000001 : 24'h000000);
      chk("t3_spike0", output_spikes[0], t3_exp[s]);
    end

    // ---- 4: integration and clamp ----
    do_reset();
    clear_cfg(63, 0, 0);
    for (int i = 0; i < M; i++) weights[i*NBITS +: NBITS] = 2'b01;
    v0_exp = '{24, 48, 0};
    for (int s = 0; s < 3; s++) begin
      run_step('1);
      chk("t4_v0", membrane_potential_out[0 +: PW], v0_exp[s]);
      chk("t4_spike0", output_spikes[0], (s == 2) ? 1'b1 : 1'b0);
    end

    // ---- 5: refractory ----
    do_reset();
    clear_cfg(1, 0, 2);
    weights[0 +: NBITS] = 2'b01;
    t5_exp = 7'b1001001;
    for (int s = 0; s < 7; s++) begin
      run_step(24'h000001);
      chk("t5_spike0", output_spikes[0], t5_exp[s]);
      chk("t5_v0", membrane_potential_out[0 +: PW], 0);
    end

    // ---- 6: negative clamp, overrun, abort by reset ----
    do_reset();
    clear_cfg(63, 0, 0);
    weights[0 +: NBITS] = 2'b01;
    run_step(24'h000001);
    chk("t6_v0_one", membrane_potential_out[0 +: PW], 1);
    weights[0 +: NBITS] = 2'b10;
    run_step(24'h000001);
    chk("t6_v0_clamp", membrane_potential_out[0 +: PW], 0);
    chk("t6_nospike", output_spikes[0], 1'b0);
    chk("t6_overrun_clear", overrun, 1'b0);

    @(negedge clk); step = 1'b1; enable = 1'b1; input_spikes = '1;
    @(posedge clk); #1; step = 1'b0;
    seen_done = 0;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      step = (c == 50);
      if (done) seen_done = 1;
    end
    step = 1'b0;
    chk("t6_overrun_set", overrun, 1'b1);
    chk("t6_busy_mid", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("t6_busy_after_reset", busy, 1'b0);
    chk("t6_overrun_after_reset", overrun, 1'b0);
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    chk("t6_no_done", seen_done, 1'b0);
    run_step(24'h000001);

    // ---- random configurations against the model ----
    for (int cfg = 0; cfg < 3; cfg++) begin
      do_reset();
      clear_cfg((cfg == 2) ? 0 : $urandom_range(1, 12), $urandom_range(0, 4), $urandom_range(0, 3));
      for (int s = 0; s < N*M; s++) begin
        weights[s*NBITS +: NBITS] = NBITS'($urandom);
        delays[s*(DW+1) +: DW+1]  = (DW+1)'($urandom);
      end
      for (int s = 0; s < 12; s++) run_step(M'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
